ram_frame_tx: RTL and testbench

Readback transmitter for the UDP RAM-write link. It reads a burst of consecutive 24-bit words from the frame RAM and serialises each one as a 6-byte frame: header `0xF1`, address high, address low, data[23:16], data[15:8], data[7:0]. This byte order is the same one the UDP receive path accepts for writes. The block sits between the RAM read port and the UDP TX byte interface, and a host echo or verify command triggers it.

---
 rtl/udp_link_pkg.sv | 38 +++
 rtl/frame_byte_ser.sv | 82 ++++++++
 rtl/ram_frame_tx.sv | 144 ++++++++++++++
 tb/tb_ram_frame_tx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_link_pkg.sv
// udp_link_pkg
// Shared definitions for the UDP RAM-write link (receive and readback paths).
// Contents:
//   ADDR_W / DATA_W  - RAM address and data widths (16 / 24)
//   FRAME_HEADER     - first byte of every frame (8'hF1)
//   FRAME_BYTES      - bytes per frame (header + 2 address + 3 data)
//   FRAME_W          - width of the address+data part of a frame (40)
//   tx_state_t       - readback transmitter FSM states
//   frame_t          - address/data pair carried by one frame
//   frame_len()      - 16-bit truncated payload length for a word count
package udp_link_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 24;
    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int FRAME_BYTES = 6;
    localparam logic [7:0] FRAME_HEADER = 8'hF1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_FIN
    } tx_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } frame_t;

    // word_cnt * 6 computed as (wc << 2) + (wc << 1), keeping only 16 bits.
    // Counts above 10922 wrap; the receive side knows the length is advisory.
    function automatic logic [15:0] frame_len(input logic [15:0] wc);
        return {wc[13:0], 2'b00} + {wc[14:0], 1'b0};
    endfunction

endpackage

// File: rtl/frame_byte_ser.sv
// frame_byte_ser
// Holds one 40-bit address/data frame and emits it as six bytes
// (HEADER, addr[15:8], addr[7:0], data[23:16], data[15:8], data[7:0])
// over a valid/ready byte stream.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - capture frame_in and start presenting byte 0
//   frame_in     - address/data pair to serialise
//   tx_data      - current byte (0 when not valid)
//   tx_valid     - byte valid, held high for the whole frame
//   tx_ready     - sink ready; a byte moves on valid & ready
//   last_hs      - pulses on the handshake of the final byte
module frame_byte_ser
    import udp_link_pkg::*;
#(
    parameter logic [7:0] HEADER = FRAME_HEADER
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  frame_t       frame_in,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         last_hs
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    logic [FRAME_W-1:0] frame_reg;
    logic [2:0]         idx_reg;
    logic               valid_reg;
    logic               handshake;
    logic [7:0]         byte_sel [FRAME_BYTES];

    // Byte 0 is the constant header; bytes 1..5 walk the frame register MSB first.
    assign byte_sel[0] = HEADER;
    generate
        for (genvar gi = 1; gi < FRAME_BYTES; gi++) begin : g_bytes
            assign byte_sel[gi] = frame_reg[FRAME_W-1-8*(gi-1) -: 8];
        end
    endgenerate

    assign handshake = valid_reg & tx_ready;
    assign last_hs   = handshake && (idx_reg == LAST_IDX);
    assign tx_valid  = valid_reg;

    always_comb begin
        tx_data = 8'h00;
        if (valid_reg) begin
            case (idx_reg)
                3'd0:    tx_data = byte_sel[0];
                3'd1:    tx_data = byte_sel[1];
                3'd2:    tx_data = byte_sel[2];
                3'd3:    tx_data = byte_sel[3];
                3'd4:    tx_data = byte_sel[4];
                3'd5:    tx_data = byte_sel[5];
                default: tx_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_reg <= '0;
            idx_reg   <= 3'd0;
            valid_reg <= 1'b0;
        end else if (load) begin
            frame_reg <= frame_in;
            idx_reg   <= 3'd0;
            valid_reg <= 1'b1;
        end else if (handshake) begin
            if (idx_reg == LAST_IDX) begin
                idx_reg   <= 3'd0;
                valid_reg <= 1'b0;
            end else begin
                idx_reg <= idx_reg + 3'd1;
            end
        end
    end

endmodule

// File: rtl/ram_frame_tx.sv
// ram_frame_tx
// Readback transmitter: reads word_cnt consecutive 24-bit RAM words starting
// at start_addr and sends each as a 6-byte frame on the UDP TX byte stream.
// One word is fetched only after the previous frame has been fully accepted.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - burst request, sampled only while idle
//   start_addr          - first RAM address of the burst
//   word_cnt            - number of words (0 gives an immediate done)
//   ram_rd_en           - one-cycle read strobe per word
//   ram_rd_addr         - read address
//   ram_rd_data         - read data, valid RD_LATENCY cycles after ram_rd_en
//   udp_tx_data/valid   - TX byte stream
//   udp_tx_ready        - TX sink ready
//   udp_tx_length       - payload length (word_cnt*6, 16-bit) of last burst
//   busy                - high from accepted start through the done cycle
//   done                - one-cycle completion pulse
module ram_frame_tx
    import udp_link_pkg::*;
#(
    parameter logic [7:0] HEADER     = FRAME_HEADER,
    parameter int         RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [15:0]       word_cnt,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [7:0]        udp_tx_data,
    output logic              udp_tx_valid,
    input  logic              udp_tx_ready,
    output logic [15:0]       udp_tx_length,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    tx_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [15:0]       remain_reg, remain_next;
    logic [15:0]       length_reg, length_next;
    logic [1:0]        lat_cnt_reg, lat_cnt_next;
    logic              ser_load;
    logic              ser_last_hs;
    frame_t            ser_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            remain_reg  <= '0;
            length_reg  <= '0;
            lat_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            remain_reg  <= remain_next;
            length_reg  <= length_next;
            lat_cnt_reg <= lat_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        remain_next  = remain_reg;
        length_next  = length_reg;
        lat_cnt_next = lat_cnt_reg;
        ser_load     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (word_cnt != 16'd0) begin
                        addr_next   = start_addr;
                        remain_next = word_cnt;
                        length_next = frame_len(word_cnt);
                        state_next  = ST_READ;
                    end else begin
                        // Empty burst: report completion without touching RAM or TX.
                        state_next = ST_FIN;
                    end
                end
            end
            ST_READ: begin
                lat_cnt_next = 2'd0;
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                // The last WAIT cycle is the one in which RAM data is valid.
                if (lat_cnt_reg == LAT_LAST) begin
                    ser_load   = 1'b1;
                    state_next = ST_SEND;
                end else begin
                    lat_cnt_next = lat_cnt_reg + 2'd1;
                end
            end
            ST_SEND: begin
                if (ser_last_hs) begin
                    if (remain_reg > 16'd1) begin
                        addr_next   = addr_reg + 1'b1;  // wraps FFFF -> 0000
                        remain_next = remain_reg - 16'd1;
                        state_next  = ST_READ;
                    end else begin
                        state_next = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ram_rd_en     = (state_reg == ST_READ);
    assign ram_rd_addr   = addr_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_FIN);
    assign udp_tx_length = length_reg;

    assign ser_frame.addr = addr_reg;
    assign ser_frame.data = ram_rd_data;

    frame_byte_ser #(
        .HEADER (HEADER)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ser_load),
        .frame_in (ser_frame),
        .tx_data  (udp_tx_data),
        .tx_valid (udp_tx_valid),
        .tx_ready (udp_tx_ready),
        .last_hs  (ser_last_hs)
    );

endmodule

// File: tb/tb_ram_frame_tx.sv
// tb_ram_frame_tx
// Directed bench for ram_frame_tx with a 1-cycle-latency RAM model.
module tb_ram_frame_tx;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] start_addr;
    logic [15:0] word_cnt;
    logic        ram_rd_en;
    logic [15:0] ram_rd_addr;
    logic [23:0] ram_rd_data;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_valid;
    logic        udp_tx_ready;
    logic [15:0] udp_tx_length;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [23:0] mem [0:65535];
    logic [7:0]  bq[$];
    logic [15:0] aq[$];
    logic [7:0]  exp_q[$];
    int          done_cnt = 0;

    ram_frame_tx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_addr    (start_addr),
        .word_cnt      (word_cnt),
        .ram_rd_en     (ram_rd_en),
        .ram_rd_addr   (ram_rd_addr),
        .ram_rd_data   (ram_rd_data),
        .udp_tx_data   (udp_tx_data),
        .udp_tx_valid  (udp_tx_valid),
        .udp_tx_ready  (udp_tx_ready),
        .udp_tx_length (udp_tx_length),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with registered read, latency 1
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    // Record accepted bytes, read addresses and done pulses mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (udp_tx_valid && udp_tx_ready) bq.push_back(udp_tx_data);
            if (ram_rd_en) aq.push_back(ram_rd_addr);
            if (done) done_cnt = done_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] a, input logic [23:0] d);
        exp_q.push_back(8'hF1);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endtask

    // Drive start for the edge T; returns in cycle T+1 with start low.
    task automatic start_burst(input logic [15:0] a, input logic [15:0] n);
        start      = 1'b1;
        start_addr = a;
        word_cnt   = n;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles since the start edge until done (first call point is T+1).
    task automatic wait_done(input string tag, input int limit, output int n);
        n = 1;
        while (!done && n < limit) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic cmp_bytes(input string tag, input int base);
        chk({tag, "_count"}, bq.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < bq.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), {24'd0, bq[base+i]}, {24'd0, exp_q[i]});
    endtask

    initial begin
        int n;
        int bb;
        int ab;
        int d0;
        logic       pv, pr;
        logic [7:0] pd;
        logic [7:0] s1 [6];

        s1[0] = 8'hF1; s1[1] = 8'h00; s1[2] = 8'h10;
        s1[3] = 8'hA1; s1[4] = 8'hB2; s1[5] = 8'hC3;

        mem[16'h0010] = 24'hA1B2C3;
        mem[16'h0011] = 24'h0D0E0F;
        mem[16'hFFFE] = 24'h123456;
        mem[16'hFFFF] = 24'h789ABC;
        mem[16'h0000] = 24'hDEF012;
        ram_rd_data   = 24'h0;

        rst_n        = 1'b0;
        start        = 1'b0;
        start_addr   = 16'h0;
        word_cnt     = 16'h0;
        udp_tx_ready = 1'b1;
        tick();
        tick();

        // ---- reset state
        chk("rst_valid", {31'd0, udp_tx_valid}, 0);
        chk("rst_data", {24'd0, udp_tx_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rden", {31'd0, ram_rd_en}, 0);
        chk("rst_addr", {16'd0, ram_rd_addr}, 0);
        chk("rst_len", {16'd0, udp_tx_length}, 0);
        rst_n = 1'b1;
        tick();

        // ---- scenario 1: single word, cycle-exact
        bb = bq.size();
        start_burst(16'h0010, 16'd1);          // now cycle T+1
        chk("s1_rden", {31'd0, ram_rd_en}, 1);
        chk("s1_rdaddr", {16'd0, ram_rd_addr}, 32'h0010);
        chk("s1_busy", {31'd0, busy}, 1);
        chk("s1_len", {16'd0, udp_tx_length}, 6);
        tick();                                 // T+2: waiting on RAM
        chk("s1_wait_valid", {31'd0, udp_tx_valid}, 0);
        chk("s1_wait_rden", {31'd0, ram_rd_en}, 0);
        for (int i = 0; i < 6; i++) begin
            tick();                             // T+3 .. T+8
            chk($sformatf("s1_valid%0d", i), {31'd0, udp_tx_valid}, 1);
            chk($sformatf("s1_byte%0d", i), {24'd0, udp_tx_data}, {24'd0, s1[i]});
            chk($sformatf("s1_done%0d", i), {31'd0, done}, 0);
        end
        tick();                                 // T+9
        chk("s1_done", {31'd0, done}, 1);
        chk("s1_done_busy", {31'd0, busy}, 1);
        chk("s1_done_valid", {31'd0, udp_tx_valid}, 0);
        tick();
        chk("s1_after_done", {31'd0, done}, 0);
        chk("s1_after_busy", {31'd0, busy}, 0);
        chk("s1_nbytes", bq.size() - bb, 6);

        // ---- scenario 2: address wrap, 3 words
        bb = bq.size();
        ab = aq.size();
        start_burst(16'hFFFE, 16'd3);
        chk("s2_len", {16'd0, udp_tx_length}, 18);
        wait_done("s2_done", 200, n);
        chk("s2_cycles", n, 25);
        tick();
        chk("s2_nreads", aq.size() - ab, 3);
        if (aq.size() - ab == 3) begin
            chk("s2_rd0", {16'd0, aq[ab]}, 32'hFFFE);
            chk("s2_rd1", {16'd0, aq[ab+1]}, 32'hFFFF);
            chk("s2_rd2", {16'd0, aq[ab+2]}, 32'h0000);
        end
        exp_q.delete();
        push_frame(16'hFFFE, 24'h123456);
        push_frame(16'hFFFF, 24'h789ABC);
        push_frame(16'h0000, 24'hDEF012);
        cmp_bytes("s2", bb);

        // ---- scenario 3: random backpressure with two 10-cycle stalls
        bb = bq.size();
        start_burst(16'h0010, 16'd1);
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        n = 0;
        while (!done && n < 400) begin
            if ((n >= 3 && n < 13) || (n >= 20 && n < 30))
                udp_tx_ready = 1'b0;
            else
                udp_tx_ready = 1'($urandom_range(0, 1));
            if (pv && !pr) begin
                chk("s3_stall_valid", {31'd0, udp_tx_valid}, 1);
                chk("s3_stall_data", {24'd0, udp_tx_data}, {24'd0, pd});
            end
            pv = udp_tx_valid;
            pr = udp_tx_ready;
            pd = udp_tx_data;
            tick();
            n++;
        end
        chk("s3_done", {31'd0, done}, 1);
        udp_tx_ready = 1'b1;
        tick();
        exp_q.delete();
        push_frame(16'h0010, 24'hA1B2C3);
        cmp_bytes("s3", bb);

        // ---- scenario 4: zero-length burst
        bb = bq.size();
        ab = aq.size();
        start_burst(16'h0123, 16'd0);           // T+1
        chk("s4_done", {31'd0, done}, 1);
        chk("s4_busy", {31'd0, busy}, 1);
        chk("s4_rden", {31'd0, ram_rd_en}, 0);
        chk("s4_valid", {31'd0, udp_tx_valid}, 0);
        tick();
        chk("s4_done_off", {31'd0, done}, 0);
        chk("s4_busy_off", {31'd0, busy}, 0);
        tick();
        tick();
        chk("s4_nreads", aq.size() - ab, 0);
        chk("s4_nbytes", bq.size() - bb, 0);

        // ---- scenario 5: start during a burst is ignored
        bb = bq.size();
        ab = aq.size();
        start_burst(16'h0010, 16'd2);           // T+1
        tick();                                 // T+2
        start      = 1'b1;
        start_addr = 16'h0500;
        word_cnt   = 16'd5;
        tick();                                 // T+3
        start = 1'b0;
        chk("s5_len_hold", {16'd0, udp_tx_length}, 12);
        n = 3;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk("s5_done", {31'd0, done}, 1);
        chk("s5_cycles", n, 17);
        tick();
        chk("s5_nreads", aq.size() - ab, 2);
        if (aq.size() - ab == 2) begin
            chk("s5_rd0", {16'd0, aq[ab]}, 32'h0010);
            chk("s5_rd1", {16'd0, aq[ab+1]}, 32'h0011);
        end
        chk("s5_len", {16'd0, udp_tx_length}, 12);
        exp_q.delete();
        push_frame(16'h0010, 24'hA1B2C3);
        push_frame(16'h0011, 24'h0D0E0F);
        cmp_bytes("s5", bb);
        chk("s5_idle", {31'd0, busy}, 0);

        // ---- scenario 6: reset during byte 3 of frame 2
        bb = bq.size();
        d0 = done_cnt;
        start_burst(16'h0010, 16'd2);
        n = 1;
        while (bq.size() - bb < 9 && n < 200) begin
            tick();
            n++;
        end
        chk("s6_reach", bq.size() - bb, 9);
        chk("s6_byte3", {24'd0, udp_tx_data}, 32'h0D);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_valid", {31'd0, udp_tx_valid}, 0);
        chk("s6_rst_busy", {31'd0, busy}, 0);
        chk("s6_rst_data", {24'd0, udp_tx_data}, 0);
        chk("s6_rst_len", {16'd0, udp_tx_length}, 0);
        chk("s6_rst_addr", {16'd0, ram_rd_addr}, 0);
        chk("s6_rst_done", {31'd0, done}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("s6_no_done", done_cnt - d0, 0);
        bb = bq.size();
        start_burst(16'h0010, 16'd1);
        wait_done("s6_done", 200, n);
        chk("s6_cycles", n, 9);
        tick();
        exp_q.delete();
        push_frame(16'h0010, 24'hA1B2C3);
        cmp_bytes("s6", bb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
